sysfun_query_sequencer: RTL and testbench

- Sequences the array-query system-function cosim datapath: `sysfun_spec_dut`, an 8-object by 4-query combinational lookup with a 128-bit selector input and a 128-bit result.
- Walks a programmed selector range and drives each selector for a fixed settle time.
- Captures each result and streams it to a consumer over a valid/ready handshake.
- Folds every result into a running signature that the cosim harness compares against the reference simulator.
- Sits between the cosim stimulus/checker harness and the DUT.

---
 rtl/sysfun_cosim_pkg.sv | 43 ++++
 rtl/sysfun_sig_fold.sv | 24 ++
 rtl/sysfun_query_sequencer.sv | 151 +++++++++++++++
 tb/tb_sysfun_query_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysfun_cosim_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sysfun_cosim_pkg
//  Brief    : Shared types, widths and the signature step for the
//             array-query system-function cosim sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package sysfun_cosim_pkg;

    localparam int SEL_W   = 5;
    localparam int DATA_W  = 128;
    localparam int SIG_W   = 32;

    // Selector fields: sel[2:0] picks the object, sel[4:3] the query pair
    localparam int OBJ_LSB = 0;
    localparam int QRY_LSB = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_EMIT    = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    // One signature update: rotate left by one, then mix in the XOR fold of
    // the result and the zero-extended selector that produced it.
    function automatic logic [SIG_W-1:0] sig_step(
        input logic [SIG_W-1:0]  sig,
        input logic [DATA_W-1:0] data,
        input logic [SEL_W:0]    sel
    );
        logic [SIG_W-1:0] f;
        f = '0;
        for (int i = 0; i < DATA_W / SIG_W; i++) begin
            f = f ^ data[i*SIG_W +: SIG_W];
        end
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ f ^ SIG_W'(sel);
    endfunction

endpackage : sysfun_cosim_pkg
`default_nettype wire

// File: rtl/sysfun_sig_fold.sv
`default_nettype none
// ============================================================================
//  Module   : sysfun_sig_fold
//  Brief    : Combinational XOR fold of a DATA_W bus into SIG_W bits.
//  Revision : 1.0 - initial release
// ============================================================================
module sysfun_sig_fold #(
    parameter int DATA_W = 128,
    parameter int SIG_W  = 32
) (
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  fold
);

    // XOR together every SIG_W-wide word of the input
    always_comb begin
        fold = '0;
        for (int i = 0; i < DATA_W / SIG_W; i++) begin
            fold = fold ^ data[i*SIG_W +: SIG_W];
        end
    end

endmodule : sysfun_sig_fold
`default_nettype wire

// File: rtl/sysfun_query_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sysfun_query_sequencer
//  Brief    : Walks a selector range into the array-query DUT, captures each
//             result, streams it over valid/ready and folds it into a
//             running signature.
//  Revision : 1.0 - initial release
// ============================================================================
module sysfun_query_sequencer #(
    parameter int SEL_W  = sysfun_cosim_pkg::SEL_W,
    parameter int DATA_W = sysfun_cosim_pkg::DATA_W,
    parameter int SETTLE = 1,
    parameter int SIG_W  = sysfun_cosim_pkg::SIG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  sel_lo,
    input  logic [SEL_W-1:0]  sel_hi,
    output logic [DATA_W-1:0] dut_in,
    input  logic [DATA_W-1:0] dut_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SEL_W-1:0]  res_sel,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [SIG_W-1:0]  sig
);
    import sysfun_cosim_pkg::*;

    state_t           r_state;
    state_t           w_next;
    // One extra bit so a range ending at the top selector cannot wrap
    logic [SEL_W:0]   r_cur_sel;
    logic [SEL_W-1:0] r_sel_hi;
    logic [3:0]       r_cnt;
    logic [SIG_W-1:0] w_fold;
    logic             w_last;
    logic             w_start;

    assign w_last  = (r_cur_sel == {1'b0, r_sel_hi});
    // A start coinciding with abort is dropped
    assign w_start = start && !abort;

    sysfun_sig_fold #(
        .DATA_W (DATA_W),
        .SIG_W  (SIG_W)
    ) u_fold (
        .data (dut_out),
        .fold (w_fold)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs; abort overrides everything
    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_FINISH);
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = (sel_lo > sel_hi) ? S_FINISH : S_DRIVE;
                end
            end
            S_DRIVE:   w_next = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
            S_SETTLE: begin
                if (r_cnt == 4'(SETTLE - 1)) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: w_next = S_EMIT;
            S_EMIT: begin
                if (res_ready) begin
                    w_next = w_last ? S_FINISH : S_DRIVE;
                end
            end
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    // Datapath: range latch, DUT drive, settle counter, capture and signature
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_sel <= '0;
            r_sel_hi  <= '0;
            r_cnt     <= '0;
            dut_in    <= '0;
            res_valid <= 1'b0;
            res_sel   <= '0;
            res_data  <= '0;
            range_err <= 1'b0;
            sig       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_sel_hi  <= sel_hi;
                        r_cur_sel <= {1'b0, sel_lo};
                        sig       <= '0;
                        range_err <= (sel_lo > sel_hi);
                    end
                end
                S_DRIVE: begin
                    dut_in <= DATA_W'(r_cur_sel);
                    r_cnt  <= '0;
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                S_CAPTURE: begin
                    if (!abort) begin
                        res_data  <= dut_out;
                        res_sel   <= r_cur_sel[SEL_W-1:0];
                        sig       <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ w_fold
                                     ^ SIG_W'(r_cur_sel);
                        res_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        res_valid <= 1'b0;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!w_last) begin
                            r_cur_sel <= r_cur_sel + (SEL_W+1)'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : sysfun_query_sequencer
`default_nettype wire

// File: tb/tb_sysfun_query_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysfun_query_sequencer
//  Brief    : Self-checking bench for sysfun_query_sequencer with a
//             scoreboard of expected results and a model of the query DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sysfun_query_sequencer;
    import sysfun_cosim_pkg::*;

    localparam int BOUND = 1000;

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [SEL_W-1:0]  sel_lo = '0;
    logic [SEL_W-1:0]  sel_hi = '0;
    logic [DATA_W-1:0] dut_in;
    logic [DATA_W-1:0] dut_out = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [SEL_W-1:0]  res_sel;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              done;
    logic              range_err;
    logic [SIG_W-1:0]  sig;

    logic              rand_mode = 1'b0;
    logic              ready_fixed = 1'b1;
    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                n_results = 0;

    sysfun_query_sequencer #(
        .SEL_W  (SEL_W),
        .DATA_W (DATA_W),
        .SETTLE (1),
        .SIG_W  (SIG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .sel_lo    (sel_lo),
        .sel_hi    (sel_hi),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sel   (res_sel),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .sig       (sig)
    );

    always #5 clk = ~clk;

    // Query table: low 64 bits hold {$bits-like, $dimensions-like} answers
    function automatic logic [DATA_W-1:0] dut_model(input logic [SEL_W-1:0] s);
        logic [31:0] v;
        v = 32'(s);
        case (s)
            5'd0:    return {64'h0, 32'd4, 32'd1};
            5'd2:    return {64'h0, 32'd24, 32'd2};
            5'd8:    return {64'h0, 32'd3, 32'd0};
            default: return {v * 32'h0100_0001, 32'hC0DE_0000 | v,
                             (v << 4) ^ 32'h55, v + 32'h100};
        endcase
    endfunction

    // Query datapath that settles one cycle after its input changes
    always @(posedge clk) dut_out <= dut_model(dut_in[SEL_W-1:0]);

    // Consumer ready: fixed or pseudo-random
    always @(posedge clk) begin
        #2;
        res_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor and stall-stability check
    logic              pv = 1'b0;
    logic              pr = 1'b0;
    logic [SEL_W-1:0]  psel = '0;
    logic [DATA_W-1:0] pdata = '0;
    always @(negedge clk) begin
        if (!rst_n || abort) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("stall_valid", DATA_W'(res_valid), 1);
                chk("stall_sel", DATA_W'(res_sel), DATA_W'(psel));
                chk("stall_data", res_data, pdata);
            end
            if (res_valid && res_ready) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_result: observed sel=%0d expected none",
                           res_sel);
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_sel", DATA_W'(res_sel), DATA_W'(e.sel));
                    chk("res_data", res_data, e.data);
                end
                n_results++;
            end
            pv = res_valid; pr = res_ready; psel = res_sel; pdata = res_data;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Full run: queue expectations, pulse start, wait for done, check totals
    task automatic run(input int lo, input int hi, output int lat);
        logic [SIG_W-1:0] s;
        int               base;
        bit               to;
        s    = '0;
        base = n_results;
        to   = 1'b0;
        for (int k = lo; k <= hi; k++) begin
            exp_q.push_back('{sel: SEL_W'(k), data: dut_model(SEL_W'(k))});
            s = sig_step(s, dut_model(SEL_W'(k)), (SEL_W+1)'(k));
        end
        step();
        start = 1'b1; sel_lo = SEL_W'(lo); sel_hi = SEL_W'(hi);
        step();
        start = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (lat >= BOUND) begin to = 1'b1; break; end
            step();
            lat++;
        end
        chk($sformatf("done_timeout_%0d_%0d", lo, hi), DATA_W'(to), 0);
        chk($sformatf("sig_%0d_%0d", lo, hi), DATA_W'(sig), DATA_W'(s));
        chk($sformatf("nres_%0d_%0d", lo, hi), DATA_W'(n_results - base),
            DATA_W'((hi >= lo) ? hi - lo + 1 : 0));
        chk($sformatf("sb_empty_%0d_%0d", lo, hi), DATA_W'(exp_q.size()), 0);
        step();
        @(negedge clk);
        chk("done_one_cycle", DATA_W'(done), 0);
        chk("idle_after_run", DATA_W'(busy), 0);
    endtask

    initial begin
        int   lat;
        int   base;
        bit   seen;
        logic [SIG_W-1:0] s_ab;

        // Reset values
        #3;
        chk("rst_dut_in", dut_in, 0);
        chk("rst_res_valid", DATA_W'(res_valid), 0);
        chk("rst_res_sel", DATA_W'(res_sel), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", DATA_W'(busy), 0);
        chk("rst_done", DATA_W'(done), 0);
        chk("rst_range_err", DATA_W'(range_err), 0);
        chk("rst_sig", DATA_W'(sig), 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Single-selector runs with known query answers
        ready_fixed = 1'b1;
        run(0, 0, lat);
        chk("lat_0_0", DATA_W'(lat), 5);
        chk("sig_const_0", DATA_W'(sig), 32'h0000_0005);
        run(8, 8, lat);
        chk("sig_const_8", DATA_W'(sig), 32'h0000_000B);
        run(2, 2, lat);
        chk("sig_const_2", DATA_W'(sig), 32'h0000_0018);

        // Full range with a stalling consumer
        rand_mode = 1'b1;
        run(0, 31, lat);
        rand_mode = 1'b0;

        // Reversed range, then a valid start clears the flag
        base = n_results;
        run(5, 3, lat);
        chk("range_err_set", DATA_W'(range_err), 1);
        chk("range_lat_le2", DATA_W'(lat <= 2), 1);
        chk("range_no_results", DATA_W'(n_results - base), 0);
        run(4, 6, lat);
        chk("range_err_clr", DATA_W'(range_err), 0);

        // Abort in EMIT while ready is high
        ready_fixed = 1'b0;
        step();
        base = n_results;
        for (int k = 10; k <= 12; k++)
            exp_q.push_back('{sel: SEL_W'(k), data: dut_model(SEL_W'(k))});
        s_ab = sig_step('0, dut_model(5'd10), 6'd10);
        start = 1'b1; sel_lo = 5'd10; sel_hi = 5'd12;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (res_valid) begin seen = 1'b1; break; end
            step();
        end
        chk("abort_reach_emit", DATA_W'(seen), 1);
        step();
        abort = 1'b1; ready_fixed = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", DATA_W'(busy), 0);
        chk("abort_valid", DATA_W'(res_valid), 0);
        chk("abort_sig_hold", DATA_W'(sig), DATA_W'(s_ab));
        chk("abort_no_handshake", DATA_W'(n_results - base), 0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done) seen = 1'b1;
            step();
            @(negedge clk);
        end
        chk("abort_no_done", DATA_W'(seen), 0);
        exp_q.delete();

        // Start and abort together in IDLE
        step();
        start = 1'b1; abort = 1'b1; sel_lo = 5'd1; sel_hi = 5'd2;
        step();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_dropped", DATA_W'(busy), 0);

        // Asynchronous reset during SETTLE
        step();
        for (int k = 3; k <= 6; k++)
            exp_q.push_back('{sel: SEL_W'(k), data: dut_model(SEL_W'(k))});
        start = 1'b1; sel_lo = 5'd3; sel_hi = 5'd6;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_dut_in", dut_in, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dut_in", dut_in, 0);
        chk("mid_rst_busy", DATA_W'(busy), 0);
        chk("mid_rst_valid", DATA_W'(res_valid), 0);
        chk("mid_rst_sel", DATA_W'(res_sel), 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_sig", DATA_W'(sig), 0);
        chk("mid_rst_done", DATA_W'(done), 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_idle", DATA_W'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sysfun_query_sequencer
`default_nettype wire
